// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter for sequence-detector benches.
// Loads a parallel word on a valid/ready handshake and shifts bits [len-1:0]
// out MSB-first, repeating the word repeat_n+1 times back-to-back.
// Optional feature macro: SEQ_PATTERN_TX_MATCH_CNT_EN enables a non-overlapping
// 0110 tracker on emitted bits; without it match_cnt is tied to zero.
module seq_pattern_tx #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned LEN_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [WIDTH-1:0] WordOne = WIDTH'(1);
    localparam logic [LEN_W-1:0] LenMax  = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] word_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [CNT_W-1:0] rep_q;

    logic [LEN_W-1:0] len_eff;
    logic [LEN_W-1:0] nxt_idx;
    logic             first_bit;
    logic             nxt_bit;
    logic             load_accept;

    assign load_accept = (state_q == StIdle) && load;

    // Effective length clamp and bit selection for the first and following bits.
    always_comb begin
        len_eff = len;
        if (len == '0 || len > LenMax) begin
            len_eff = LenMax;
        end
        first_bit = |(data_in & (WordOne << (len_eff - LenOne)));
        // At bit 0 wrap to the MSB so repeats follow with no bubble.
        nxt_idx = (idx_q != '0) ? (idx_q - LenOne) : (len_q - LenOne);
        nxt_bit = |(word_q & (WordOne << nxt_idx));
    end

    // Transfer FSM with registered handshake and serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            ready     <= 1'b1;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            word_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (load) begin
                        word_q    <= data_in;
                        len_q     <= len_eff;
                        idx_q     <= len_eff - LenOne;
                        rep_q     <= repeat_n;
                        out       <= first_bit;
                        out_valid <= 1'b1;
                        ready     <= 1'b0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (idx_q != '0 || rep_q != '0) begin
                        idx_q <= nxt_idx;
                        out   <= nxt_bit;
                        if (idx_q == '0) begin
                            rep_q <= rep_q - CNT_W'(1);
                        end
                    end else begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q   <= StIdle;
                    ready     <= 1'b1;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEQ_PATTERN_TX_MATCH_CNT_EN
    typedef enum logic [1:0] {TrS0, TrS1, TrS2, TrS3} trk_e;

    trk_e             trk_q;
    logic [CNT_W-1:0] cnt_q;

    // Non-overlapping 0110 tracker over valid emitted bits; count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            trk_q <= TrS0;
            cnt_q <= '0;
        end else if (load_accept) begin
            trk_q <= TrS0;
        end else if (out_valid) begin
            case (trk_q)
                TrS0: trk_q <= out ? TrS0 : TrS1;
                TrS1: trk_q <= out ? TrS2 : TrS1;
                TrS2: trk_q <= out ? TrS3 : TrS1;
                TrS3: begin
                    trk_q <= TrS0;
                    if (!out && cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: trk_q <= TrS0;
            endcase
        end
    end

    assign match_cnt = cnt_q;
`else
    logic unused_load_accept;
    assign unused_load_accept = load_accept;
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx with a bit-level scoreboard and an
// independent greedy 0110 counter model.
module tb_seq_pattern_tx;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned LEN_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_n;
    logic             load;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             done;
    logic [CNT_W-1:0] match_cnt;

    int   tests = 0;
    int   fails = 0;
    logic exp_q[$];
    int   exp_match = 0;

    seq_pattern_tx #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_in(data_in),
        .len(len),
        .repeat_n(repeat_n),
        .load(load),
        .ready(ready),
        .out(out),
        .out_valid(out_valid),
        .done(done),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag);
        logic e;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_bit"}, 32'(out), 32'(e));
        end
    endtask

    // Drive a load request and push the expected stream; returns bit count.
    task automatic start_load(input logic [15:0] d, input logic [4:0] l,
                              input logic [7:0] r, output int n);
        int   eff;
        int   cnt;
        int   i;
        logic bits[$];
        eff = (l == 0 || l > 16) ? 16 : int'(l);
        for (int rr = 0; rr <= int'(r); rr++) begin
            for (int b = eff - 1; b >= 0; b--) begin
                bits.push_back(d[b]);
                exp_q.push_back(d[b]);
            end
        end
        n = bits.size();
        cnt = 0;
        i = 0;
        while (i + 3 < n) begin
            if (bits[i] == 1'b0 && bits[i+1] == 1'b1 && bits[i+2] == 1'b1 && bits[i+3] == 1'b0) begin
                cnt++;
                i += 4;
            end else begin
                i++;
            end
        end
`ifdef SEQ_PATTERN_TX_MATCH_CNT_EN
        exp_match = exp_match + cnt;
        if (exp_match > 255) exp_match = 255;
`endif
        data_in  = d;
        len      = l;
        repeat_n = r;
        load     = 1'b1;
    endtask

    task automatic run_xfer(input logic [15:0] d, input logic [4:0] l,
                            input logic [7:0] r, input string tag);
        int n;
        check({tag, "_ready_pre"}, 32'(ready), 32'd1);
        start_load(d, l, r, n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            load = 1'b0;
            check_bit(tag);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_out"}, 32'(out), 32'd0);
        check({tag, "_done_ready"}, 32'(ready), 32'd0);
        check({tag, "_match"}, 32'(match_cnt), 32'(exp_match));
        @(negedge clk);
        check({tag, "_ready_post"}, 32'(ready), 32'd1);
        check({tag, "_done_low"}, 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_match = 0;
        exp_q.delete();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_match", 32'(match_cnt), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        load     = 1'b1;
        data_in  = 16'h0006;
        len      = 5'd4;
        repeat_n = 8'd0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset_ready", 32'(ready), 32'd1);
            check("reset_valid", 32'(out_valid), 32'd0);
            check("reset_done", 32'(done), 32'd0);
            check("reset_match", 32'(match_cnt), 32'd0);
        end
        reset = 1'b0;
        load  = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_out", 32'(out), 32'd0);

        run_xfer(16'h0006, 5'd4, 8'd0, "single");

        do_reset();
        run_xfer(16'h0006, 5'd4, 8'd3, "repeat");

        do_reset();
        run_xfer(16'h0036, 5'd7, 8'd0, "nonovl7");
        run_xfer(16'h0066, 5'd8, 8'd0, "nonovl8");
        run_xfer(16'h000B, 5'd5, 8'd2, "len5rep2");

        // Ignored load during shift, then reset while bit 3 is on the line.
        check("abort_ready_pre", 32'(ready), 32'd1);
        start_load(16'h0006, 5'd4, 8'd1, n);
        @(negedge clk);
        check_bit("abort");
        data_in = 16'hFFFF;
        len     = 5'd16;
        load    = 1'b1;
        @(negedge clk);
        check_bit("abort");
        load = 1'b0;
        @(negedge clk);
        check_bit("abort");
        @(negedge clk);
        check_bit("abort");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_match = 0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_match", 32'(match_cnt), 32'd0);
        @(negedge clk);
        check("abort_nodone", 32'(done), 32'd0);
        check("abort_idle", 32'(out_valid), 32'd0);

        run_xfer(16'hA5A5, 5'd0, 8'd0, "clamp0");
        run_xfer(16'h1234, 5'd31, 8'd0, "clamp31");

        do_reset();
        run_xfer(16'h0006, 5'd4, 8'd255, "saturate");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
